avalon_interval_timer_mc: RTL

//  Parametrised multi-channel interval timer on an Avalon-MM slave. Next generation of the

---
 rtl/avalon_interval_timer_mc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/avalon_interval_timer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_interval_timer_mc
//  Description : N-channel interval timer on an Avalon-MM slave with snapshot
//                readback and per-channel / combined interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_interval_timer_mc #(
    parameter int          N_CHANNELS     = 2,
    parameter int          COUNTER_WIDTH  = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1DCD64FF,
    parameter bit          RESET_RUNNING  = 1'b0,
    localparam int         AW             = $clog2(N_CHANNELS) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [N_CHANNELS-1:0] irq,
    output logic                  irq_any
);

    localparam int                     c_ch_bits = $clog2(N_CHANNELS);
    localparam logic [COUNTER_WIDTH-1:0] c_default = DEFAULT_PERIOD[COUNTER_WIDTH-1:0];
    localparam logic [COUNTER_WIDTH-1:0] c_one     = COUNTER_WIDTH'(1);

    logic [31:0]                 w_ch;
    logic                        w_ch_valid;
    logic [1:0]                  w_reg;
    logic                        w_wr;
    logic [N_CHANNELS-1:0][31:0] w_rd_ch;
    logic [31:0]                 w_rd_next;

    // A single-channel build has no channel field in the address.
    generate
        if (c_ch_bits > 0) begin : g_ch_dec
            assign w_ch = 32'(address[AW-1:2]);
        end else begin : g_ch_one
            assign w_ch = '0;
        end
    endgenerate

    assign w_reg      = address[1:0];
    assign w_wr       = chipselect & ~write_n;
    assign w_ch_valid = (w_ch < 32'(N_CHANNELS));

    generate
        for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
            logic [COUNTER_WIDTH-1:0] r_cnt;
            logic [COUNTER_WIDTH-1:0] r_per;
            logic [COUNTER_WIDTH-1:0] r_snap;
            logic                     r_to;
            logic                     r_ito;
            logic                     r_run;
            logic                     r_cont;
            logic                     w_hit;
            logic                     w_tmo;
            logic                     w_wr_stat;
            logic                     w_wr_ctrl;
            logic                     w_wr_per;
            logic                     w_wr_snap;

            assign w_hit     = w_wr & w_ch_valid & (w_ch == 32'(i));
            assign w_tmo     = r_run & (r_cnt == '0);
            assign w_wr_stat = w_hit & (w_reg == 2'd0);
            assign w_wr_ctrl = w_hit & (w_reg == 2'd1);
            assign w_wr_per  = w_hit & (w_reg == 2'd2);
            assign w_wr_snap = w_hit & (w_reg == 2'd3);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt  <= c_default;
                    r_per  <= c_default;
                    r_snap <= '0;
                    r_to   <= 1'b0;
                    r_ito  <= 1'b0;
                    r_run  <= RESET_RUNNING;
                    r_cont <= RESET_RUNNING;
                end else begin
                    // A timeout in the same cycle as a STATUS clear must not be lost.
                    if (w_tmo) begin
                        r_to <= 1'b1;
                    end else if (w_wr_stat) begin
                        r_to <= 1'b0;
                    end

                    if (w_wr_per) begin
                        r_cnt <= writedata[COUNTER_WIDTH-1:0];
                    end else if (w_tmo) begin
                        r_cnt <= r_per;
                    end else if (r_run) begin
                        r_cnt <= r_cnt - c_one;
                    end

                    if (w_wr_per) begin
                        r_per <= writedata[COUNTER_WIDTH-1:0];
                    end

                    // Software commands take precedence over the one-shot auto-stop.
                    if (w_wr_per) begin
                        r_run <= 1'b0;
                    end else if (w_wr_ctrl && writedata[3]) begin
                        r_run <= 1'b0;
                    end else if (w_wr_ctrl && writedata[2]) begin
                        r_run <= 1'b1;
                    end else if (w_tmo) begin
                        r_run <= r_cont;
                    end

                    if (w_wr_ctrl) begin
                        r_ito  <= writedata[0];
                        r_cont <= writedata[1];
                    end

                    if (w_wr_snap) begin
                        r_snap <= r_cnt;
                    end
                end
            end

            always_comb begin
                w_rd_ch[i] = '0;
                case (w_reg)
                    2'd0:    w_rd_ch[i] = {30'b0, r_run, r_to};
                    2'd1:    w_rd_ch[i] = {30'b0, r_cont, r_ito};
                    2'd2:    w_rd_ch[i] = 32'(r_per);
                    default: w_rd_ch[i] = 32'(r_snap);
                endcase
            end

            assign irq[i] = r_to & r_ito;
        end
    endgenerate

    always_comb begin
        w_rd_next = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (w_ch_valid && (w_ch == 32'(k))) begin
                w_rd_next = w_rd_ch[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_next;
        end
    end

    assign irq_any = |irq;

endmodule
`default_nettype wire
